arith_unit_pipe: RTL
====================

ARITH_UNIT_PIPE -- requirements
Module: arith_unit_pipe

Interface
REQ-001 Parameter: DATA_SIZE, 8, operand/result width in bits (>=2).
REQ-002 Parameter: SAT_EN, 0, 1 = unsigned saturating result; 0 = wrap-around.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operand set this cycle.
REQ-007 a_in  input  DATA_SIZE  operand A.
REQ-008 b_in  input  DATA_SIZE  operand B.
REQ-009 carry_in  input  1  external carry/borrow for ADC/SBB.
REQ-010 use_flag_in  input  1  1 = ADC/SBB take internal carry flag instead of carry_in.
REQ-011 op_code  input  3  operation select (REQ-015).
REQ-012 out_valid  output  1  result registers hold a valid result.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 result_out, carry_out, zero_out, neg_out, overflow_out  output  DATA_SIZE,1,1,1,1  result and flags.

Function
REQ-015 Op codes: 000 PASS (result=A, acc<=A, C=0); 001 ADD A+B; 010 ADC A+B+c; 011 SUB A-B; 100 SBB A-B-c; 101 INC A+1; 110 DEC A-1; 111 ACC acc+A, acc<=result.
REQ-016 Arithmetic at DATA_SIZE+1 bits; carry_out = bit DATA_SIZE (carry for add-type, borrow for sub-type).
REQ-017 c for ADC/SBB = carry flag if use_flag_in=1 at acceptance, else carry_in; use_flag_in sampled with operands.
REQ-018 Carry flag register = carry_out of last op written to output registers; PASS clears it.
REQ-019 overflow_out = two's-complement signed overflow of the op (0 for PASS); neg_out = result_out MSB; zero_out = (result_out==0).
REQ-020 SAT_EN=1: add-type ops (ADD, ADC, INC, ACC) with carry give all-ones; sub-type (SUB, SBB, DEC) with borrow give 0; carry_out/flag still raw carry; zero/neg from saturated value; ACC stores saturated value.
REQ-021 Pipeline: stage 1 registers operands/op/carry select; stage 2 computes and registers result and flags.
REQ-022 advance = !out_valid || out_ready; in_ready = advance (combinational, no in_valid dependency).
REQ-023 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-024 On advance: stage 1 loads inputs and s1_valid<=in_valid; stage 2 loads stage-1 result, out_valid<=s1_valid.
REQ-025 Latency: result visible 2 cycles after acceptance edge when out_ready held 1; throughput 1 op/cycle.
REQ-026 !advance: all stage registers, carry flag, accumulator frozen; outputs stable.
REQ-027 Carry flag and accumulator update only when a valid stage-1 op moves to stage 2; bubbles change nothing.
REQ-028 Back-to-back ADC/SBB with use_flag_in=1 see the carry of the immediately preceding op, no stall.
REQ-029 Strict in-order; no op dropped or duplicated under any out_ready pattern.

Reset
REQ-030 reset=1 asynchronously clears s1_valid, out_valid, result_out, all flag outputs, carry flag, accumulator to 0.
REQ-031 Reset mid-operation discards all in-flight ops; first op after deassertion behaves as post-reset.
REQ-032 in_ready = 1 during and after reset (out_valid=0).

Verification
REQ-033 ADD A=0xF0 B=0x20, out_ready=1 -> 2 cycles later result 0x10, C=1, Z=0, N=0, V=0.
REQ-034 ADD 0xFF+0x01 then ADC 0x00+0x00 use_flag_in=1 carry_in=0, back-to-back -> 0x00 C=1 Z=1, then 0x01 C=0.
REQ-035 SUB 0x10-0x20: SAT_EN=0 -> 0xF0 C=1 N=1 V=0; SAT_EN=1 -> 0x00 C=1 Z=1 N=0.
REQ-036 PASS 0x05, ACC 0x03, ACC 0xFE -> 0x05, 0x08 C=0, 0x06 C=1.
REQ-037 Streaming with out_ready low 3 cycles -> in_ready low, result_out stable, all results delivered in order after release.
REQ-038 reset pulse while out_valid=1 and stage 1 full -> out_valid=0 immediately; next ADC use_flag_in=1 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: two-stage pipelined arithmetic unit with carry flag and accumulator.
//
// Stage 1 registers the operand set: A, B, op, external carry and the carry-select bit.
// Stage 2 computes the result, registers it with the flags, and updates the carry flag
// and the accumulator.
// Handshake: valid/ready on both sides. in_ready is combinational from the output
// register state, so it never depends on in_valid.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   operand-set handshake
//   a_in, b_in            operands (DATA_SIZE bits)
//   carry_in              external carry/borrow for ADC/SBB
//   use_flag_in           1 = ADC/SBB use the internal carry flag instead of carry_in
//   op_code               000 PASS, 001 ADD, 010 ADC, 011 SUB, 100 SBB, 101 INC, 110 DEC,
//                         111 ACC
//   out_valid / out_ready result handshake
//   result_out, carry_out, zero_out, neg_out, overflow_out   result and flags
module arith_unit_pipe #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned SAT_EN    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  input  logic                 carry_in,
  input  logic                 use_flag_in,
  input  logic [2:0]           op_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] result_out,
  output logic                 carry_out,
  output logic                 zero_out,
  output logic                 neg_out,
  output logic                 overflow_out
);

  localparam int unsigned Msb = DATA_SIZE - 1;
  localparam logic [DATA_SIZE-1:0] One = {{(DATA_SIZE-1){1'b0}}, 1'b1};

  localparam logic [2:0] OpPass = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpAdc  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpSbb  = 3'b100;
  localparam logic [2:0] OpInc  = 3'b101;
  localparam logic [2:0] OpDec  = 3'b110;
  localparam logic [2:0] OpAcc  = 3'b111;

  // Stage 1
  logic                 s1_valid_q;
  logic [DATA_SIZE-1:0] a_q, b_q;
  logic [2:0]           op_q;
  logic                 cin_q, use_flag_q;

  // Stage 2 / architectural state
  logic                 out_valid_q;
  logic [DATA_SIZE-1:0] result_q, acc_q;
  logic                 flag_q, zero_q, neg_q, ovf_q;

  logic                 advance;
  logic [DATA_SIZE-1:0] opa, opb, raw, res_d, acc_d;
  logic [DATA_SIZE:0]   sum;
  logic                 cx, c_sel, is_sub, carry_d, ovf_d;

  assign advance = !out_valid_q || out_ready;

  always_comb begin
    // The flag register always holds the carry of the op now sitting in the output
    // registers, i.e. the op immediately preceding the one in stage 1, so no stall
    // is needed for back-to-back ADC/SBB.
    c_sel   = use_flag_q ? flag_q : cin_q;
    opa     = a_q;
    opb     = b_q;
    cx      = 1'b0;
    is_sub  = 1'b0;
    case (op_q)
      OpAdc:   cx = c_sel;
      OpSub:   is_sub = 1'b1;
      OpSbb: begin
        is_sub = 1'b1;
        cx     = c_sel;
      end
      OpInc:   opb = One;
      OpDec: begin
        opb    = One;
        is_sub = 1'b1;
      end
      OpAcc: begin
        opa = acc_q;
        opb = a_q;
      end
      default: ;
    endcase

    if (is_sub) begin
      sum = {1'b0, opa} - {1'b0, opb} - {{DATA_SIZE{1'b0}}, cx};
    end else begin
      sum = {1'b0, opa} + {1'b0, opb} + {{DATA_SIZE{1'b0}}, cx};
    end
    raw     = sum[Msb:0];
    carry_d = sum[DATA_SIZE];

    // Signed overflow: add overflows when like-signed operands give a differently
    // signed result; subtract when unlike-signed operands flip the sign of A.
    if (is_sub) begin
      ovf_d = (opa[Msb] != opb[Msb]) && (raw[Msb] != opa[Msb]);
    end else begin
      ovf_d = (opa[Msb] == opb[Msb]) && (raw[Msb] != opa[Msb]);
    end

    res_d = raw;
    if ((SAT_EN != 0) && carry_d) begin
      res_d = is_sub ? '0 : '1;
    end

    if (op_q == OpPass) begin
      res_d   = a_q;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end

    acc_d = acc_q;
    if (op_q == OpPass) begin
      acc_d = a_q;
    end else if (op_q == OpAcc) begin
      acc_d = res_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      use_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      a_q         <= a_in;
      b_q         <= b_in;
      op_q        <= op_code;
      cin_q       <= carry_in;
      use_flag_q  <= use_flag_in;
      out_valid_q <= s1_valid_q;
      // Bubbles leave result, flags and accumulator untouched.
      if (s1_valid_q) begin
        result_q <= res_d;
        flag_q   <= carry_d;
        zero_q   <= (res_d == '0);
        neg_q    <= res_d[Msb];
        ovf_q    <= ovf_d;
        acc_q    <= acc_d;
      end
    end
  end

  assign in_ready     = advance;
  assign out_valid    = out_valid_q;
  assign result_out   = result_q;
  assign carry_out    = flag_q;
  assign zero_out     = zero_q;
  assign neg_out      = neg_q;
  assign overflow_out = ovf_q;

endmodule
